// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller.
// Accepts a pair of WIDTH-bit operands plus carry-in, then reuses a single
// one-bit full-adder cell once per bit position, LSB first, and returns the
// WIDTH-bit sum with carry-out over a valid/ready handshake.

module fa_dataflow (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_fa_s;
    logic             w_fa_co;

    // The single shared cell always looks at the current LSBs and carry.
    fa_dataflow u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    // Handshake outputs come from the state register; rst also masks in_ready
    // so that no request looks accepted while reset is being applied.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign s         = r_res;
    assign co        = r_carry;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: accept in IDLE, finish after the last bit, release on consume.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_BIT) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on acceptance, shift one bit per cycle in RUN,
    // hold everything in DONE so the result stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= ci;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_co;
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CW'(1);
                end
                default: begin
                    r_res   <= r_res;
                    r_carry <= r_carry;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus randomized bench for serial_add_ctrl (WIDTH = 8).
// Expected sums come from plain integer addition a + b + ci.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y, input logic c);
        int t;
        t = int'(x) + int'(y) + int'(c);
        return t[8:0];
    endfunction

    // Accept one request, wait for the result (bounded), check latency and
    // value, consume it and check in_ready the cycle after.
    task automatic do_op(input string tag, input logic [7:0] xa, input logic [7:0] xb, input logic xc);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = xa; b = xb; ci = xc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_sum"}, {23'd0, co, s}, {23'd0, ref_sum(xa, xb, xc)});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [8:0] exp_q[$];
        logic [8:0] hold_res;
        logic [8:0] e;
        int n_in, n_out, cyc, last_acc, limit;
        bit in_f, out_f, seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; ci = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);

        // Directed arithmetic cases
        do_op("ripple", 8'hFF, 8'h01, 1'b0);
        do_op("cin_chain", 8'hA5, 8'h5A, 1'b1);
        do_op("plain", 8'h12, 8'h34, 1'b0);

        // Backpressure in DONE with in_valid pulses carrying new operands
        a = 8'h3C; b = 8'hC4; ci = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        hold_res = ref_sum(8'h3C, 8'hC4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", {23'd0, co, s}, {23'd0, hold_res});
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            in_valid = 1'(i % 2 == 0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_result_end", {23'd0, co, s}, {23'd0, hold_res});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_ready_after", 32'(in_ready), 32'd1);
        chk("bp_valid_after", 32'(out_valid), 32'd0);
        do_op("bp_next", 8'h01, 8'h02, 1'b0);

        // Reset during bit 3 of F0 + 0F
        a = 8'hF0; b = 8'h0F; ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_idle", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        do_op("after_abort", 8'h80, 8'h80, 1'b0);

        // Back-to-back random regression
        n_in = 0; n_out = 0; cyc = 0; last_acc = -1; limit = 256 * 10 + 100;
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        while (n_out < 256 && cyc < limit) begin
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (out_f) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("reg_sum", {23'd0, co, s}, {23'd0, e});
                end else begin
                    chk("reg_unexpected_out", 32'd1, 32'd0);
                end
            end
            if (in_f) begin
                exp_q.push_back(ref_sum(a, b, ci));
                if (last_acc >= 0) chk("reg_ii", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
            end
            tick();
            cyc++;
            if (in_f) begin
                n_in++;
                a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
                if (n_in == 256) in_valid = 1'b0;
            end
            if (out_f) n_out++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("reg_out_count", 32'(n_out), 32'd256);
        chk("reg_hs_balance", 32'(n_out), 32'(n_in));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

- Bit-serial adder controller: accepts one pair of WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Sequences a single one-bit full-adder cell (fa_dataflow) across all bit positions, LSB first, one bit per clock.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Lets the team reuse the verified one-bit cell for multi-bit addition when area matters more than latency.

## Interface

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept operands; high only in IDLE and only while rst is low.
- a  input  WIDTH  operand A; sampled on the input handshake edge.
- b  input  WIDTH  operand B; sampled on the input handshake edge.
- ci  input  1  carry-in; sampled on the input handshake edge.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum; meaningful only while out_valid = 1.
- co  output  1  carry-out; meaningful only while out_valid = 1.

## Operation

- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready at an edge, the controller loads a and b into operand shift registers, loads the carry register with ci, and clears the bit counter (clog2(WIDTH) bits). The next state is RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - The full-adder cell inputs are the LSB of the A shift register, the LSB of the B shift register, and the carry register.
  - Each edge:
    - the cell s output shifts into the result register from the MSB side;
    - the cell co output loads the carry register;
    - both operand registers shift right by one;
    - the counter increments.
  - At the edge where the counter equals WIDTH-1, the last bit is processed and the next state is DONE.
- DONE:
  - out_valid = 1, s = result register, co = carry register; all three are held stable while out_ready = 0.
  - On out_valid && out_ready at an edge, the next state is IDLE.
  - in_ready stays 0, so in_valid during DONE is ignored and nothing is latched.
- Arithmetic: {co, s} = a + b + ci, evaluated at WIDTH+1 bits; there is no saturation, and overflow appears only in co.
- Reset: at any rst edge the state goes to IDLE, and out_valid, s, co, the counter, the operand registers and the carry register all go to 0.
- Reset mid-RUN or mid-DONE aborts the operation silently. No out_valid is produced for the aborted request.
- rst has priority over both handshakes in the same cycle.
- In RUN, s reflects the partially shifted result register. Consumers must not sample it.

## Timing

- Input handshake at edge E0: RUN occupies the cycles after E0 through E0+WIDTH-1. Bit i is processed at edge E0+1+i.
- out_valid rises after edge E0+WIDTH, i.e. exactly WIDTH cycles after acceptance.
- Output handshake at edge D: state is IDLE after D. in_ready is high in the cycle after D.
- No new request can be accepted in the same edge as the output handshake.
- Minimum initiation interval is WIDTH+2 cycles, with in_valid held high and out_ready held high.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- After reset deassertion: in_ready = 1 in the first cycle with rst low. out_valid = 0, s = 0, co = 0.

## Test plan

All scenarios use WIDTH = 8.

- Reset: hold rst 3 cycles, then release -> in_ready = 1, out_valid = 0, s = 8'h00, co = 0. in_ready stays 0 while rst is high.
- Carry ripple: a = 8'hFF, b = 8'h01, ci = 0 -> s = 8'h00, co = 1. out_valid rises exactly 8 cycles after the acceptance edge.
- Carry-in through full chain: a = 8'hA5, b = 8'h5A, ci = 1 -> s = 8'h00, co = 1. With a = 8'h12, b = 8'h34, ci = 0 -> s = 8'h46, co = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while pulsing in_valid with new operands:
  - s, co and out_valid stay stable and in_ready stays 0;
  - the pulsed operands are not latched;
  - after out_ready = 1, in_ready is high exactly one cycle later.
- Reset mid-operation: assert rst for one cycle at bit 3 of a = 8'hF0 + b = 8'h0F:
  - the next cycle is IDLE with out_valid = 0, and no result ever appears;
  - a following request a = 8'h80, b = 8'h80, ci = 0 -> s = 8'h00, co = 1.
- Regression: 256 random back-to-back requests with in_valid and out_ready held high:
  - every {co, s} equals a + b + ci;
  - the initiation interval is exactly 10 cycles;
  - the count of out_valid handshakes equals the count of in_valid handshakes.
